ace_instbuf: RTL and testbench
==============================

// Module: ace_instbuf
// PURPOSE
//  Decode-stage-0 instruction buffer: the receiving end of the fetch-to-decode interface. Each cycle it
//  accepts the registered fetch bundle (up to 8 x 32-bit instructions plus a valid mask) into a circular
//  FIFO, and presents up to ISSUE_W oldest instructions in order to decode. It drives instbuf_full back to
//  fetch, which holds its d0 bundle while full is high. A retire flush empties it.
// PARAMETERS
//  FETCH_W  8   instructions per fetch bundle (fixed at 8 by the fetch interface)
//  DEPTH    16  FIFO entries; power of 2, >= 2*FETCH_W
//  ISSUE_W  4   instructions presented to decode per cycle; 1..FETCH_W
// PORTS
//  clock           in   1             clock
//  reset_n         in   1             asynchronous reset, active low
//  flush_rt_i      in   1             retire flush: discard all contents
//  inst_vld_d0_i   in   8             bundle valid mask; bit k = slot k
//  inst_d0_i       in   256           bundle data; slot k at [32k+31:32k]; slot 0 is oldest
//  dec_stall_i     in   1             decode cannot accept this cycle
//  instbuf_full_o  out  1             to fetch: cannot accept a full bundle; fetch holds d0 bundle
//  instbuf_cnt_o   out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  dec_vld_o       out  ISSUE_W       per-slot valid to decode; always a prefix (bit 0 first)
//  dec_inst_o      out  32*ISSUE_W    slot j = entry at head+j; slot j at [32j+31:32j]
// BEHAVIOUR
//  State: wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH); cnt ($clog2(DEPTH)+1 bits); DEPTH x 32 RAM.
//  Reset (async, reset_n=0): wr_ptr=rd_ptr=cnt=0; instbuf_full_o=0, instbuf_cnt_o=0, dec_vld_o=0,
//   dec_inst_o=0. RAM contents are not reset.
//  instbuf_full_o = (cnt > DEPTH-FETCH_W). It is a function of registered cnt only; it never depends
//   combinationally on any input.
//  Enqueue count n_enq = number of consecutive 1s in inst_vld_d0_i starting at bit 0 (0..8). Mask bits
//   above the first 0 are ignored (an illegal non-prefix mask such as 8'b0000_0101 gives n_enq=1).
//  Enqueue enable: en = ~instbuf_full_o & ~flush_rt_i. When en=1, slot k (k<n_enq) is written to
//   RAM[wr_ptr+k]; then wr_ptr += n_enq. When full, the held bundle is not taken and is re-presented;
//   it is accepted in the first cycle in which full is low. This prevents both loss and duplication.
//  Dequeue: n_avail = min(cnt, ISSUE_W). dec_vld_o[j] = (j < n_avail) & ~flush_rt_i.
//   dec_inst_o slot j = RAM[rd_ptr+j] when valid, else 0.
//   n_deq = (dec_stall_i | flush_rt_i) ? 0 : n_avail. Decode consumes every presented instruction, or none.
//   rd_ptr += n_deq.
//  cnt_next = cnt + (en ? n_enq : 0) - n_deq. Latency is 1 cycle from enqueue to visibility at decode;
//   there is no bypass path. Simultaneous enqueue and dequeue in the same cycle is legal, including when
//   cnt=0 (dec_vld_o=0 that cycle) and when cnt=DEPTH-FETCH_W.
//  Overflow is impossible: en requires cnt <= DEPTH-8.
//  Flush (flush_rt_i=1): next cycle wr_ptr=rd_ptr=cnt=0. Enqueue and dequeue are suppressed and
//   dec_vld_o=0 in the flush cycle itself. Flush overrides stall and full. The bundle fetch loads
//   during flush is invalid by construction.
//  Pointer wrap: RAM index = (ptr+k) mod DEPTH. A bundle may straddle the wrap point.
//  Assertions: cnt <= DEPTH; dec_vld_o is always a prefix.
// TESTING
//  1 Reset: hold reset_n=0 with inst_vld_d0_i=8'hFF -> full=0, cnt=0, dec_vld_o=0; no write happens.
//  2 Fill: 2 bundles of 8'hFF (data 0..15), dec_stall_i=1 -> cnt=8 then 16; full=1 once cnt>8; a 3rd
//    held bundle is not taken until decode drains it.
//  3 Drain/order: after test 2, dec_stall_i=0 -> dec_vld_o=4'hF each cycle, data 0,1,2,3 / 4..7 /
//    ...; cnt 16,12,8,...; full drops once cnt<=8 and the held bundle is taken exactly once.
//  4 Wrap and partial: set wr_ptr=12 by traffic, then enqueue 8'h3F (6 insts) -> entries 12..15,0,1
//    are written; dec_inst_o stays in order across the wrap; a cnt=2 tail gives dec_vld_o=4'b0011.
//  5 Simultaneous: cnt=8, enqueue 8'hFF with no stall -> cnt_next = 8+8-4 = 12, full=1 next cycle;
//    non-prefix mask 8'h05 enqueues 1.
//  6 Flush: cnt=10 with flush_rt_i=1 and a valid bundle -> dec_vld_o=0 that cycle, next cycle cnt=0,
//    full=0; no stale instruction ever appears.

Source files
------------

// File: rtl/ace_instbuf.sv
// Decode-stage-0 instruction buffer: circular FIFO fed by fetch bundles (prefix-masked),
// presenting up to ISSUE_W oldest instructions in order to decode.
module ace_instbuf #(
  parameter int unsigned FETCH_W = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ISSUE_W = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush_rt_i,
  input  logic [FETCH_W-1:0]         inst_vld_d0_i,
  input  logic [32*FETCH_W-1:0]      inst_d0_i,
  input  logic                       dec_stall_i,
  output logic                       instbuf_full_o,
  output logic [$clog2(DEPTH):0]     instbuf_cnt_o,
  output logic [ISSUE_W-1:0]         dec_vld_o,
  output logic [32*ISSUE_W-1:0]      dec_inst_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] n_enq, n_avail, n_deq;
  logic          enq_en;
  logic [31:0]   mem_q [DEPTH];

  // Full only looks at registered occupancy so fetch sees no combinational path.
  assign instbuf_full_o = cnt_q > CW'(DEPTH - FETCH_W);
  assign instbuf_cnt_o  = cnt_q;
  assign enq_en         = ~instbuf_full_o & ~flush_rt_i;

  // Count leading ones from slot 0; anything past the first hole is ignored.
  always_comb begin
    n_enq = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      if (inst_vld_d0_i[k] && (n_enq == CW'(k))) n_enq = CW'(k + 1);
    end
  end

  always_comb begin
    n_avail    = (cnt_q < CW'(ISSUE_W)) ? cnt_q : CW'(ISSUE_W);
    n_deq      = (dec_stall_i | flush_rt_i) ? '0 : n_avail;
    dec_vld_o  = '0;
    dec_inst_o = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      dec_vld_o[j] = (CW'(j) < n_avail) & ~flush_rt_i;
      if (dec_vld_o[j]) dec_inst_o[32*j +: 32] = mem_q[rd_ptr_q + PW'(j)];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_rt_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + (enq_en ? PW'(n_enq) : '0);
      rd_ptr_d = rd_ptr_q + PW'(n_deq);
      cnt_d    = cnt_q + (enq_en ? n_enq : '0) - n_deq;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (enq_en) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (CW'(k) < n_enq) mem_q[wr_ptr_q + PW'(k)] <= inst_d0_i[32*k +: 32];
      end
    end
  end

  cnt_le_depth: assert property (@(posedge clock) disable iff (!reset_n)
    cnt_q <= CW'(DEPTH));
  vld_is_prefix: assert property (@(posedge clock) disable iff (!reset_n)
    (dec_vld_o & (dec_vld_o + ISSUE_W'(1))) == '0);

endmodule

// File: tb/tb_ace_instbuf.sv
// Scoreboard bench for ace_instbuf: driver pushes accepted words, negedge monitor pops on issue.
module tb_ace_instbuf;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         flush_rt_i;
  logic [7:0]   inst_vld_d0_i;
  logic [255:0] inst_d0_i;
  logic         dec_stall_i;
  logic         instbuf_full_o;
  logic [4:0]   instbuf_cnt_o;
  logic [3:0]   dec_vld_o;
  logic [127:0] dec_inst_o;

  ace_instbuf #(.FETCH_W(8), .DEPTH(16), .ISSUE_W(4)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .flush_rt_i     (flush_rt_i),
    .inst_vld_d0_i  (inst_vld_d0_i),
    .inst_d0_i      (inst_d0_i),
    .dec_stall_i    (dec_stall_i),
    .instbuf_full_o (instbuf_full_o),
    .instbuf_cnt_o  (instbuf_cnt_o),
    .dec_vld_o      (dec_vld_o),
    .dec_inst_o     (dec_inst_o)
  );

  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  int          mcnt   = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int prefix_len(input logic [7:0] m);
    int n = 0;
    for (int k = 0; k < 8; k++) if (m[k] && n == k) n = k + 1;
    return n;
  endfunction

  // Apply one cycle of stimulus; words the buffer will accept go straight into the scoreboard.
  task automatic step(input logic [7:0] vld, input int base, input bit stall, input bit flush);
    @(posedge clock);
    #1;
    inst_vld_d0_i = vld;
    dec_stall_i   = stall;
    flush_rt_i    = flush;
    for (int k = 0; k < 8; k++) inst_d0_i[32*k +: 32] = 32'(base + k);
    if (!flush && mcnt <= 8) begin
      for (int k = 0; k < prefix_len(vld); k++) exp_q.push_back(32'(base + k));
    end
    #3;
  endtask

  // Monitor: compare presented slots against the scoreboard, pop on consumption.
  always @(negedge clock) begin
    if (mon_en) begin
      int          n_av;
      int          n_deq;
      logic [3:0]  exp_vld;
      logic [31:0] exp_w;
      n_av = (mcnt < 4) ? mcnt : 4;
      if (flush_rt_i) n_av = 0;
      exp_vld = 4'((1 << n_av) - 1);
      chk("mon_cnt", 32'(instbuf_cnt_o), 32'(mcnt));
      chk("mon_full", 32'(instbuf_full_o), 32'(mcnt > 8));
      chk("mon_vld", 32'(dec_vld_o), 32'(exp_vld));
      if (exp_q.size() < n_av) begin
        chk("mon_sb_underflow", 32'(exp_q.size()), 32'(n_av));
      end else begin
        for (int j = 0; j < 4; j++) begin
          exp_w = (j < n_av) ? exp_q[j] : 32'h0;
          chk("mon_inst", dec_inst_o[32*j +: 32], exp_w);
        end
      end
      n_deq = (dec_stall_i || flush_rt_i) ? 0 : n_av;
      for (int j = 0; j < n_deq; j++) if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (flush_rt_i) begin
        exp_q.delete();
        mcnt = 0;
      end else begin
        mcnt = mcnt + ((mcnt <= 8) ? prefix_len(inst_vld_d0_i) : 0) - n_deq;
      end
    end
  end

  initial begin
    reset_n       = 1'b0;
    flush_rt_i    = 1'b0;
    dec_stall_i   = 1'b0;
    inst_vld_d0_i = 8'hFF;
    inst_d0_i     = '1;

    // Reset held with a valid bundle present
    repeat (3) @(posedge clock);
    #4;
    chk("rst_cnt", 32'(instbuf_cnt_o), 32'd0);
    chk("rst_full", 32'(instbuf_full_o), 32'd0);
    chk("rst_vld", 32'(dec_vld_o), 32'd0);
    chk("rst_inst", dec_inst_o[31:0], 32'd0);
    @(posedge clock);
    #1;
    inst_vld_d0_i = 8'h00;
    reset_n       = 1'b1;
    mcnt          = 0;
    mon_en        = 1'b1;
    step(8'h00, 0, 1'b0, 1'b0);
    chk("post_rst_cnt", 32'(instbuf_cnt_o), 32'd0);

    // Fill with decode stalled; third bundle is held
    step(8'hFF, 0, 1'b1, 1'b0);
    step(8'hFF, 8, 1'b1, 1'b0);
    chk("fill_cnt8", 32'(instbuf_cnt_o), 32'd8);
    chk("fill_full8", 32'(instbuf_full_o), 32'd0);
    step(8'hFF, 16, 1'b1, 1'b0);
    chk("fill_cnt16", 32'(instbuf_cnt_o), 32'd16);
    chk("fill_full16", 32'(instbuf_full_o), 32'd1);
    step(8'hFF, 16, 1'b1, 1'b0);
    chk("hold_cnt16", 32'(instbuf_cnt_o), 32'd16);

    // Drain in order; held bundle taken once full drops
    step(8'hFF, 16, 1'b0, 1'b0);
    chk("drain_vld", 32'(dec_vld_o), 32'hF);
    chk("drain_d0", dec_inst_o[31:0], 32'd0);
    step(8'hFF, 16, 1'b0, 1'b0);
    chk("drain_cnt12", 32'(instbuf_cnt_o), 32'd12);
    chk("drain_d4", dec_inst_o[31:0], 32'd4);
    step(8'hFF, 16, 1'b0, 1'b0);
    chk("drain_cnt8", 32'(instbuf_cnt_o), 32'd8);
    chk("drain_full8", 32'(instbuf_full_o), 32'd0);
    step(8'h00, 0, 1'b0, 1'b0);
    chk("take_cnt12", 32'(instbuf_cnt_o), 32'd12);
    repeat (3) step(8'h00, 0, 1'b0, 1'b0);
    chk("drain_empty", 32'(instbuf_cnt_o), 32'd0);

    // Wrap: move pointers to 12, then a 6-wide bundle straddles the end
    step(8'h0F, 100, 1'b0, 1'b0);
    step(8'h00, 0, 1'b0, 1'b0);
    step(8'h3F, 200, 1'b1, 1'b0);
    step(8'h00, 0, 1'b0, 1'b0);
    chk("wrap_cnt6", 32'(instbuf_cnt_o), 32'd6);
    chk("wrap_d3", dec_inst_o[127:96], 32'd203);
    step(8'h00, 0, 1'b0, 1'b0);
    chk("tail_vld", 32'(dec_vld_o), 32'b0011);
    chk("tail_d1", dec_inst_o[63:32], 32'd205);
    chk("tail_d2", dec_inst_o[95:64], 32'd0);
    step(8'h00, 0, 1'b0, 1'b0);

    // Simultaneous enqueue/dequeue at cnt=8, then a non-prefix mask
    step(8'hFF, 300, 1'b1, 1'b0);
    step(8'hFF, 308, 1'b0, 1'b0);
    chk("sim_cnt8", 32'(instbuf_cnt_o), 32'd8);
    step(8'h05, 400, 1'b0, 1'b0);
    chk("sim_cnt12", 32'(instbuf_cnt_o), 32'd12);
    chk("sim_full12", 32'(instbuf_full_o), 32'd1);
    step(8'h05, 400, 1'b0, 1'b0);
    step(8'h00, 0, 1'b0, 1'b0);
    chk("npfx_cnt5", 32'(instbuf_cnt_o), 32'd5);
    repeat (2) step(8'h00, 0, 1'b0, 1'b0);
    chk("npfx_empty", 32'(instbuf_cnt_o), 32'd0);

    // Flush at cnt=10 with a valid bundle on the input
    step(8'hFF, 500, 1'b1, 1'b0);
    step(8'h03, 508, 1'b1, 1'b0);
    step(8'hFF, 600, 1'b0, 1'b1);
    chk("flush_cnt10", 32'(instbuf_cnt_o), 32'd10);
    chk("flush_vld", 32'(dec_vld_o), 32'd0);
    step(8'h00, 0, 1'b0, 1'b0);
    chk("flush_cnt0", 32'(instbuf_cnt_o), 32'd0);
    chk("flush_full", 32'(instbuf_full_o), 32'd0);
    chk("flush_vld0", 32'(dec_vld_o), 32'd0);
    step(8'h0F, 700, 1'b0, 1'b0);
    step(8'h00, 0, 1'b0, 1'b0);
    chk("post_flush_d0", dec_inst_o[31:0], 32'd700);
    repeat (3) step(8'h00, 0, 1'b0, 1'b0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
